// File: rtl/jtframe_spi_upload.sv
// jtframe_spi_upload
// SPI slave (mode 0) that streams game memory to the IO-controller MCU.
// The MCU sends a command byte and a 24-bit big-endian start address,
// then clocks one dummy byte. After that it reads a stream of bytes that
// are fetched through a req/ack byte-read port with an auto-incrementing
// address. The SPI pins are oversampled on clk_sys.
//
// Ports
//   clk_sys    system clock; all logic runs on it
//   rst_n      asynchronous active-low reset
//   spi_sck    SPI clock (CPOL=0, CPHA=0), asynchronous to clk_sys
//   spi_ss     chip select, active low
//   spi_di     MOSI
//   spi_do     MISO data, MSB first
//   spi_do_oe  MISO output enable
//   rd_addr    byte address of the read request
//   rd_req     read request, held with rd_addr stable until rd_ack
//   rd_ack     rd_data is valid in the cycle where rd_ack=1
//   rd_data    read byte
//   uploading  high while sending the dummy byte or streaming
//   underrun   sticky: a FILL byte was sent; cleared on spi_ss falling edge
module jtframe_spi_upload #(
  parameter int         ADDRW      = 23,
  parameter logic [7:0] UPLOAD_CMD = 8'h56,
  parameter logic [7:0] FILL       = 8'h00
)(
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             spi_sck,
  input  logic             spi_ss,
  input  logic             spi_di,
  output logic             spi_do,
  output logic             spi_do_oe,
  output logic [ADDRW-1:0] rd_addr,
  output logic             rd_req,
  input  logic             rd_ack,
  input  logic [7:0]       rd_data,
  output logic             uploading,
  output logic             underrun
);

  // Receive shifter only needs to hold the address bits kept in rd_addr,
  // but never less than one command byte.
  localparam int SRW = (ADDRW > 8) ? ADDRW : 8;

  typedef enum logic [2:0] {IDLE, CMD, IGNORE, ADDR, DUMMY, STREAM} state_t;
  state_t state, state_nxt;

  logic [2:0]     sck_s, ss_s;
  logic [1:0]     di_s;
  logic           ss_high, ss_fall, sck_rise, sck_fall, byte_end;
  logic [2:0]     bit_cnt;
  logic [1:0]     byte_cnt;
  logic [SRW-2:0] rx_sr;
  logic [SRW-1:0] rx_nxt;
  logic [7:0]     tx_sr;
  logic [7:0]     pf_data;
  logic           pf_vld;
  logic           tx_fill;
  logic           sending;

  assign ss_high  = ss_s[1];
  assign ss_fall  = ~ss_s[1] & ss_s[2];
  // SCK edges are ignored once chip select is seen high, so a final SCK
  // fall that coincides with deselect never starts a new byte.
  assign sck_rise = ~ss_high &  sck_s[1] & ~sck_s[2];
  assign sck_fall = ~ss_high & ~sck_s[1] &  sck_s[2];
  assign rx_nxt   = {rx_sr, di_s[1]};
  assign byte_end = sck_rise & (bit_cnt == 3'd7);
  assign sending  = (state == DUMMY) || (state == STREAM);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    spi_do_oe = 1'b0;
    uploading = 1'b0;
    case (state)
      IDLE:   if (ss_fall && !rd_req) state_nxt = CMD;
      CMD:    if (byte_end) state_nxt = (rx_nxt[7:0] == UPLOAD_CMD) ? ADDR : IGNORE;
      IGNORE: state_nxt = IGNORE;
      ADDR:   if (byte_end && byte_cnt == 2'd2) state_nxt = DUMMY;
      DUMMY: begin
        spi_do_oe = 1'b1;
        uploading = 1'b1;
        if (byte_end) state_nxt = STREAM;
      end
      STREAM: begin
        spi_do_oe = 1'b1;
        uploading = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (ss_high) state_nxt = IDLE;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sck_s    <= '0;
      ss_s     <= '0;
      di_s     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      pf_data  <= '0;
      pf_vld   <= 1'b0;
      tx_fill  <= 1'b0;
      spi_do   <= 1'b0;
      rd_addr  <= '0;
      rd_req   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sck_s <= {sck_s[1:0], spi_sck};
      ss_s  <= {ss_s[1:0], spi_ss};
      di_s  <= {di_s[0], spi_di};

      if (sck_rise) begin
        rx_sr   <= rx_nxt[SRW-2:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7 && state == ADDR) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd2) begin
            rd_addr <= rx_nxt[ADDRW-1:0];
            rd_req  <= 1'b1;
          end
        end
        // underrun is flagged only once a FILL byte has been fully clocked out
        if (bit_cnt == 3'd7 && state == STREAM && tx_fill) underrun <= 1'b1;
      end

      if (sck_fall) begin
        if (sending) begin
          if (bit_cnt == 3'd0) begin
            if (state == STREAM && pf_vld) begin
              spi_do  <= pf_data[7];
              tx_sr   <= {pf_data[6:0], 1'b0};
              pf_vld  <= 1'b0;
              rd_req  <= 1'b1;
              tx_fill <= 1'b0;
            end else begin
              // dummy byte, or the prefetch missed its slot
              spi_do  <= FILL[7];
              tx_sr   <= {FILL[6:0], 1'b0};
              tx_fill <= (state == STREAM);
            end
          end else begin
            spi_do <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b0};
          end
        end else begin
          spi_do <= 1'b0;
        end
      end

      // An ack that lands after deselect only closes the handshake; data is dropped.
      if (rd_ack && rd_req) begin
        rd_req  <= 1'b0;
        rd_addr <= rd_addr + ADDRW'(1);
        if (sending) begin
          pf_data <= rd_data;
          pf_vld  <= 1'b1;
        end
      end

      if (state == IDLE) begin
        pf_vld <= 1'b0;
        if (ss_fall) begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
          underrun <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_spi_upload.sv
`timescale 1ns/1ps
module tb_jtframe_spi_upload;
  localparam int         ADDRW      = 23;
  localparam logic [7:0] UPLOAD_CMD = 8'h56;
  localparam logic [7:0] FILL       = 8'h00;

  logic             clk_sys = 1'b0;
  logic             rst_n   = 1'b0;
  logic             spi_sck = 1'b0;
  logic             spi_ss  = 1'b1;
  logic             spi_di  = 1'b0;
  logic             spi_do, spi_do_oe;
  logic [ADDRW-1:0] rd_addr;
  logic             rd_req;
  logic             rd_ack  = 1'b0;
  logic [7:0]       rd_data = 8'h00;
  logic             uploading, underrun;

  jtframe_spi_upload #(.ADDRW(ADDRW), .UPLOAD_CMD(UPLOAD_CMD), .FILL(FILL)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .spi_sck(spi_sck), .spi_ss(spi_ss),
    .spi_di(spi_di), .spi_do(spi_do), .spi_do_oe(spi_do_oe), .rd_addr(rd_addr),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .uploading(uploading),
    .underrun(underrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;
  bit hold_ack  = 1'b0;
  bit fixed_lat = 1'b0;

  logic [7:0]       exp_byte_q[$];
  logic [ADDRW-1:0] exp_addr_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void unexp(string name, logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h, nothing expected at %0t", name, act, $time);
  endfunction

  // memory contents seen by the read port
  function automatic logic [7:0] mem(logic [ADDRW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Reference model: expected MISO bytes and read-request addresses of an
  // upload that clocks nbits in total (command + address + dummy + data).
  task automatic plan(input logic [23:0] addr, input int nbits, input bit starve);
    logic [ADDRW-1:0] a;
    int dbits, full, started;
    a       = addr[ADDRW-1:0];
    dbits   = nbits - 40;
    full    = dbits / 8;
    started = (dbits + 7) / 8;
    exp_byte_q.push_back(FILL);
    for (int k = 0; k < full; k++)
      exp_byte_q.push_back(starve ? FILL : mem(a + ADDRW'(k)));
    if (starve) exp_addr_q.push_back(a);
    else for (int k = 0; k <= started; k++) exp_addr_q.push_back(a + ADDRW'(k));
  endtask

  // memory responder
  initial begin : responder
    int lat;
    forever begin
      @(negedge clk_sys);
      if (rd_req === 1'b1 && !hold_ack) begin
        lat = fixed_lat ? 2 : int'($urandom_range(1, 4));
        repeat (lat - 1) @(negedge clk_sys);
        rd_data = mem(rd_addr);
        rd_ack  = 1'b1;
        @(negedge clk_sys);
        rd_ack  = 1'b0;
        rd_data = 8'($urandom);
      end
    end
  end

  // MISO monitor: assembles complete bytes while the output is enabled
  initial begin : byte_mon
    logic [7:0] sh;
    int nb;
    sh = '0;
    nb = 0;
    forever begin
      @(posedge spi_sck or posedge spi_ss or negedge rst_n);
      if (spi_ss || !rst_n) nb = 0;
      else if (spi_do_oe === 1'b1) begin
        sh = {sh[6:0], spi_do};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_byte_q.size() == 0) unexp("miso_byte_unexpected", sh);
          else chk("miso_byte", sh, exp_byte_q.pop_front());
        end
      end
    end
  end

  // read-request monitor
  initial begin : req_mon
    logic prev, cur_vld;
    logic [ADDRW-1:0] cur;
    prev = 1'b0; cur_vld = 1'b0; cur = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (rd_req === 1'b1 && !prev) begin
        if (exp_addr_q.size() == 0) begin
          unexp("rd_req_unexpected", rd_addr);
          cur_vld = 1'b0;
        end else begin
          cur = exp_addr_q.pop_front();
          cur_vld = 1'b1;
          chk("rd_addr", rd_addr, cur);
        end
      end else if (rd_req === 1'b1 && cur_vld) begin
        chk("rd_addr_hold", rd_addr, cur);
      end
      prev = (rd_req === 1'b1);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic wait_free();
    int n;
    n = 0;
    while (rd_req !== 1'b0 && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    chk("rd_req_drained", rd_req, 0);
  endtask

  // SPI master, mode 0. The last SCK fall coincides with deselect.
  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int nbits,
                      input int half, input bit upl, input bit exp_under, input bit do_rst);
    logic [31:0] hdr;
    hdr = {cmd, addr};
    wait_free();
    @(negedge clk_sys);
    spi_ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_di = (i < 32) ? hdr[31 - i] : 1'($urandom);
      repeat (half) @(negedge clk_sys);
      if (i == 0) chk("underrun_cleared", underrun, 0);
      spi_sck = 1'b1;
      if (i % 8 == 4) begin
        chk("spi_do_oe", spi_do_oe, 32'(upl && i >= 32));
        chk("uploading", uploading, 32'(upl && i >= 32));
      end
      if (do_rst && i == nbits - 1) begin
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {spi_do, spi_do_oe, rd_req, uploading, underrun}, 0);
        chk("async_rst_addr", rd_addr, 0);
        @(negedge clk_sys);
        spi_sck = 1'b0;
        spi_ss  = 1'b1;
        repeat (4) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk("post_rst_ctrl", {spi_do, spi_do_oe, rd_req, uploading, underrun}, 0);
        return;
      end
      repeat (half) @(negedge clk_sys);
      if (i == nbits - 1) spi_ss = 1'b1;
      spi_sck = 1'b0;
    end
    repeat (3) @(negedge clk_sys);
    chk("oe_off_after_ss", spi_do_oe, 0);
    chk("uploading_off", uploading, 0);
    repeat (4) @(negedge clk_sys);
    chk("underrun_end", underrun, 32'(exp_under));
  endtask

  initial begin : main
    logic [23:0] ra;
    logic [7:0]  c;
    int nb, hf;
    rst_n = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("reset_ctrl", {spi_do, spi_do_oe, rd_req, uploading, underrun}, 0);
    chk("reset_addr", rd_addr, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    chk("idle_ctrl", {spi_do, spi_do_oe, rd_req, uploading, underrun}, 0);

    // basic upload from 0x10, 2-cycle acks
    fixed_lat = 1'b1;
    plan(24'h000010, 72, 1'b0);
    xfer(UPLOAD_CMD, 24'h000010, 72, 5, 1'b1, 1'b0, 1'b0);

    // foreign command is ignored
    xfer(8'h12, 24'h000000, 40, 5, 1'b0, 1'b0, 1'b0);

    // starved prefetch, then a clean transaction
    fixed_lat = 1'b0;
    hold_ack  = 1'b1;
    ra = 24'($urandom);
    plan(ra, 64, 1'b1);
    xfer(UPLOAD_CMD, ra, 64, 5, 1'b1, 1'b1, 1'b0);
    hold_ack = 1'b0;
    ra = 24'($urandom);
    plan(ra, 56, 1'b0);
    xfer(UPLOAD_CMD, ra, 56, int'($urandom_range(4, 6)), 1'b1, 1'b0, 1'b0);

    // deselect after 3 bits of the second data byte, then upload from 0x20
    ra = 24'($urandom);
    plan(ra, 51, 1'b0);
    xfer(UPLOAD_CMD, ra, 51, 5, 1'b1, 1'b0, 1'b0);
    plan(24'h000020, 48, 1'b0);
    xfer(UPLOAD_CMD, 24'h000020, 48, 5, 1'b1, 1'b0, 1'b0);

    // address wrap at the top of the ADDRW space
    plan(24'h7FFFFF, 56, 1'b0);
    xfer(UPLOAD_CMD, 24'h7FFFFF, 56, 5, 1'b1, 1'b0, 1'b0);

    // reset mid-stream, then the basic upload again
    ra = 24'($urandom);
    plan(ra, 51, 1'b0);
    xfer(UPLOAD_CMD, ra, 51, 5, 1'b1, 1'b0, 1'b1);
    fixed_lat = 1'b1;
    plan(24'h000010, 72, 1'b0);
    xfer(UPLOAD_CMD, 24'h000010, 72, 5, 1'b1, 1'b0, 1'b0);
    fixed_lat = 1'b0;

    // randomized traffic
    for (int t = 0; t < 10; t++) begin
      hf = int'($urandom_range(4, 6));
      ra = 24'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        do c = 8'($urandom); while (c == UPLOAD_CMD);
        xfer(c, ra, 40, hf, 1'b0, 1'b0, 1'b0);
      end else begin
        nb = 40 + 8 * int'($urandom_range(1, 5));
        plan(ra, nb, 1'b0);
        xfer(UPLOAD_CMD, ra, nb, hf, 1'b1, 1'b0, 1'b0);
      end
    end

    repeat (20) @(negedge clk_sys);
    chk("bytes_outstanding", exp_byte_q.size(), 0);
    chk("reqs_outstanding", exp_addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
